// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: store-size encoding, owner select
// and the bundled memory request.
package dmem_pkg;

    typedef enum logic [1:0] {
        MS_NONE = 2'b00,
        MS_BYTE = 2'b01,
        MS_HALF = 2'b10,
        MS_WORD = 2'b11
    } memsize_e;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_DMA  = 2'b10
    } arb_owner_e;

    typedef struct packed {
        memsize_e    we;
        logic [31:0] a;
        logic [31:0] wd;
    } dmem_req_t;

    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive denied DMA cycles and raises force_o once MAX_WAIT is
// reached, so the arbiter can steal one slot from the core.
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req_i,
    input  logic dma_gnt_i,
    output logic force_o
);

    localparam logic [WAIT_W:0] MAX_W = (WAIT_W + 1)'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              force_q, force_d;
    logic [WAIT_W:0]   wait_inc;

    assign wait_inc = {1'b0, wait_q} + 1'b1;

    always_comb begin
        wait_d  = wait_q;
        force_d = force_q;
        if (!dma_req_i || dma_gnt_i) begin
            // A withdrawn request also drops a pending force, so no slot is stolen.
            wait_d  = '0;
            force_d = 1'b0;
        end else if (wait_inc == MAX_W) begin
            wait_d  = '0;
            force_d = 1'b1;
        end else begin
            wait_d  = wait_inc[WAIT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q  <= '0;
            force_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            force_q <= force_d;
        end
    end

    assign force_o = force_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between the core MEM stage and a DMA master. Core wins conflicts;
// with DMEM_ARB_STARVE_EN defined a starvation counter forces a one-cycle DMA slot.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic [1:0]  MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    input  logic        dma_req,
    input  logic [1:0]  dma_we,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_wd,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic [1:0]  mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    logic       core_req;
    logic       force_dma;
    arb_owner_e owner;
    dmem_req_t  core_s, dma_s, mem_s;

    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    assign core_req = MemReadM | (MemWriteM != 2'b00);
    assign core_s   = '{we: memsize_e'(MemWriteM), a: ALUResultM, wd: WriteDataM};
    assign dma_s    = '{we: memsize_e'(dma_we), a: dma_adr, wd: dma_wd};

`ifdef DMEM_ARB_STARVE_EN
    dmem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .dma_req_i (dma_req),
        .dma_gnt_i (dma_gnt),
        .force_o   (force_dma)
    );
`else
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
    assign force_dma       = 1'b0;
`endif

    always_comb begin
        owner = OWN_IDLE;
        if (rst)
            owner = OWN_IDLE;
        else if (force_dma && dma_req)
            owner = OWN_DMA;
        else if (core_req)
            owner = OWN_CORE;
        else if (dma_req)
            owner = OWN_DMA;
    end

    always_comb begin
        mem_s     = '{we: MS_NONE, a: ALUResultM, wd: WriteDataM};
        dma_gnt   = 1'b0;
        StallM    = 1'b0;
        ReadDataM = mem_rd;
        case (owner)
            OWN_CORE: mem_s = core_s;
            OWN_DMA: begin
                mem_s   = dma_s;
                dma_gnt = 1'b1;
`ifdef DMEM_ARB_STARVE_EN
                StallM  = core_req;
`endif
            end
            default: ;
        endcase
    end

    assign mem_we = mem_s.we;
    assign mem_a  = mem_s.a;
    assign mem_wd = mem_s.wd;

    // Read data is captured only on a read grant and held otherwise.
    always_comb begin
        rvalid_d = dma_gnt & (memsize_e'(dma_we) == MS_NONE);
        rdata_d  = rvalid_d ? mem_rd : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

endmodule
